// File: rtl/counter_pkg.sv
// Shared mode type and encodings for the multi-channel counter.
package counter_pkg;

  typedef enum logic [1:0] {
    MODE_SAT    = 2'b00,
    MODE_WRAP   = 2'b01,
    MODE_RELOAD = 2'b10,
    MODE_RSVD   = 2'b11
  } cnt_mode_t;

  localparam logic [1:0] MODE_SAT_ENC    = 2'b00;
  localparam logic [1:0] MODE_WRAP_ENC   = 2'b01;
  localparam logic [1:0] MODE_RELOAD_ENC = 2'b10;
  localparam logic [1:0] MODE_RSVD_ENC   = 2'b11;

endpackage

// File: rtl/counter_channel.sv
// One up/down counter channel with load, reload register and overflow/underflow events.
// Sticky event flags are built only when COUNTER_STICKY_FLAGS_EN is defined.
module counter_channel
  import counter_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_value,
  input  logic              up,
  input  logic              down,
  input  logic [STEP_W-1:0] step,
  input  logic [1:0]        mode,
  input  logic              flag_clr,
  output logic [WIDTH-1:0]  count,
  output logic              at_max,
  output logic              at_min,
  output logic              ovf_pulse,
  output logic              udf_pulse,
  output logic              ovf_sticky,
  output logic              udf_sticky
);

  logic [WIDTH-1:0] reload_q;
  logic [WIDTH-1:0] step_ext;
  logic [WIDTH-1:0] next_count;
  logic [WIDTH:0]   sum;
  logic             ovf_evt;
  logic             udf_evt;
  cnt_mode_t        cur_mode;

  assign step_ext = WIDTH'(step);
  assign sum      = {1'b0, count} + {1'b0, step_ext};
  assign cur_mode = cnt_mode_t'(mode);
  assign at_max   = &count;
  assign at_min   = (count == '0);

  // The extra sum bit is the overflow; a zero step can never produce an event.
  always_comb begin
    next_count = count;
    ovf_evt    = 1'b0;
    udf_evt    = 1'b0;
    if (load) begin
      next_count = load_value;
    end else if ((up ^ down) && (step_ext != '0)) begin
      if (up) begin
        if (sum[WIDTH]) begin
          ovf_evt = 1'b1;
          case (cur_mode)
            MODE_WRAP:   next_count = sum[WIDTH-1:0];
            MODE_RELOAD: next_count = reload_q;
            default:     next_count = '1;
          endcase
        end else begin
          next_count = sum[WIDTH-1:0];
        end
      end else begin
        if (step_ext > count) begin
          udf_evt = 1'b1;
          case (cur_mode)
            MODE_WRAP:   next_count = count - step_ext;
            MODE_RELOAD: next_count = reload_q;
            default:     next_count = '0;
          endcase
        end else begin
          next_count = count - step_ext;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count     <= '0;
      reload_q  <= '0;
      ovf_pulse <= 1'b0;
      udf_pulse <= 1'b0;
    end else begin
      count     <= next_count;
      ovf_pulse <= ovf_evt;
      udf_pulse <= udf_evt;
      if (load) begin
        reload_q <= load_value;
      end
    end
  end

`ifdef COUNTER_STICKY_FLAGS_EN
  // A new event outranks a clear arriving in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_sticky <= 1'b0;
      udf_sticky <= 1'b0;
    end else begin
      if (ovf_evt) begin
        ovf_sticky <= 1'b1;
      end else if (flag_clr) begin
        ovf_sticky <= 1'b0;
      end
      if (udf_evt) begin
        udf_sticky <= 1'b1;
      end else if (flag_clr) begin
        udf_sticky <= 1'b0;
      end
    end
  end
`else
  logic unused_flag_clr;
  assign unused_flag_clr = flag_clr;
  assign ovf_sticky      = 1'b0;
  assign udf_sticky      = 1'b0;
`endif

endmodule

// File: rtl/multi_channel_counter.sv
// N_CH independent counter channels sharing clock, reset and step.
// Sticky flags are enabled by defining COUNTER_STICKY_FLAGS_EN.
module multi_channel_counter
  import counter_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int N_CH   = 2,
  parameter int STEP_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH-1:0]       load,
  input  logic [N_CH*WIDTH-1:0] load_value,
  input  logic [N_CH-1:0]       up,
  input  logic [N_CH-1:0]       down,
  input  logic [STEP_W-1:0]     step,
  input  logic [N_CH*2-1:0]     mode,
  input  logic [N_CH-1:0]       flag_clr,
  output logic [N_CH*WIDTH-1:0] count,
  output logic [N_CH-1:0]       at_max,
  output logic [N_CH-1:0]       at_min,
  output logic [N_CH-1:0]       ovf_pulse,
  output logic [N_CH-1:0]       udf_pulse,
  output logic [N_CH-1:0]       ovf_sticky,
  output logic [N_CH-1:0]       udf_sticky
);

  for (genvar i = 0; i < N_CH; i++) begin : ch_g
    counter_channel #(
      .WIDTH (WIDTH),
      .STEP_W(STEP_W)
    ) u_channel (
      .clk       (clk),
      .rst       (rst),
      .load      (load[i]),
      .load_value(load_value[i*WIDTH +: WIDTH]),
      .up        (up[i]),
      .down      (down[i]),
      .step      (step),
      .mode      (mode[i*2 +: 2]),
      .flag_clr  (flag_clr[i]),
      .count     (count[i*WIDTH +: WIDTH]),
      .at_max    (at_max[i]),
      .at_min    (at_min[i]),
      .ovf_pulse (ovf_pulse[i]),
      .udf_pulse (udf_pulse[i]),
      .ovf_sticky(ovf_sticky[i]),
      .udf_sticky(udf_sticky[i])
    );
  end

endmodule

// File: tb/tb_multi_channel_counter.sv
// Self-checking bench for multi_channel_counter: directed scenarios plus randomized
// traffic checked against an integer reference model of the counting rules.
module tb_multi_channel_counter;

`ifdef COUNTER_STICKY_FLAGS_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [1:0]  load;
  logic [15:0] load_value;
  logic [1:0]  up;
  logic [1:0]  down;
  logic [3:0]  step;
  logic [3:0]  mode;
  logic [1:0]  flag_clr;
  logic [15:0] count;
  logic [1:0]  at_max;
  logic [1:0]  at_min;
  logic [1:0]  ovf_pulse;
  logic [1:0]  udf_pulse;
  logic [1:0]  ovf_sticky;
  logic [1:0]  udf_sticky;

  int vectors;
  int miscompares;

  int m_cnt[2];
  int m_rel[2];
  bit m_ovf[2];
  bit m_udf[2];
  bit m_os[2];
  bit m_us[2];

  multi_channel_counter #(.WIDTH(8), .N_CH(2), .STEP_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_value(load_value),
    .up        (up),
    .down      (down),
    .step      (step),
    .mode      (mode),
    .flag_clr  (flag_clr),
    .count     (count),
    .at_max    (at_max),
    .at_min    (at_min),
    .ovf_pulse (ovf_pulse),
    .udf_pulse (udf_pulse),
    .ovf_sticky(ovf_sticky),
    .udf_sticky(udf_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    load = '0; load_value = '0; up = '0; down = '0;
    step = '0; mode = '0; flag_clr = '0;
  endtask

  task automatic model_reset();
    for (int ch = 0; ch < 2; ch++) begin
      m_cnt[ch] = 0; m_rel[ch] = 0; m_ovf[ch] = 0;
      m_udf[ch] = 0; m_os[ch] = 0; m_us[ch] = 0;
    end
  endtask

  task automatic do_reset();
    clear_inputs();
    @(negedge clk);
    rst = 1'b1;
    #2;
    rst = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  // Advance the model from the current inputs, then take one clock edge.
  task automatic tick();
    for (int ch = 0; ch < 2; ch++) begin
      int md;
      int s;
      int nc;
      bit o;
      bit u;
      md = int'(mode[ch*2 +: 2]);
      nc = m_cnt[ch];
      o = 0;
      u = 0;
      if (load[ch]) begin
        nc = int'(load_value[ch*8 +: 8]);
        m_rel[ch] = nc;
      end else if ((up[ch] != down[ch]) && (step != 0)) begin
        if (up[ch]) begin
          s = m_cnt[ch] + int'(step);
          if (s > 255) begin
            o = 1;
            nc = (md == 1) ? s - 256 : (md == 2) ? m_rel[ch] : 255;
          end else begin
            nc = s;
          end
        end else begin
          s = m_cnt[ch] - int'(step);
          if (s < 0) begin
            u = 1;
            nc = (md == 1) ? s + 256 : (md == 2) ? m_rel[ch] : 0;
          end else begin
            nc = s;
          end
        end
      end
      m_cnt[ch] = nc;
      m_ovf[ch] = o;
      m_udf[ch] = u;
      if (STICKY) begin
        if (o) m_os[ch] = 1;
        else if (flag_clr[ch]) m_os[ch] = 0;
        if (u) m_us[ch] = 1;
        else if (flag_clr[ch]) m_us[ch] = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    mode = 4'b0000; step = 4'd1; up = 2'b01;
    repeat (5) tick();
    vectors++;
    if (count[7:0] !== 8'h05) begin
      miscompares++;
      $display("[TB] FAIL reset_precount: got %h expected %h", count[7:0], 8'h05);
    end
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if (count !== 16'h0000 || at_min !== 2'b11 || at_max !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL reset_async_count: count %h at_min %b at_max %b expected 0000 11 00",
               count, at_min, at_max);
    end
    vectors++;
    if ({ovf_pulse, udf_pulse, ovf_sticky, udf_sticky} !== 8'h00) begin
      miscompares++;
      $display("[TB] FAIL reset_async_flags: got %h expected 00",
               {ovf_pulse, udf_pulse, ovf_sticky, udf_sticky});
    end
    clear_inputs();
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  task automatic test_sat_up();
    do_reset();
    mode = 4'b0000; load = 2'b01; load_value = 16'h00FE;
    tick();
    load = 2'b00; step = 4'd1; up = 2'b01;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (count[7:0] !== 8'hFF || ovf_pulse[0] !== (i > 0) || at_max[0] !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL sat_up[%0d]: count %h ovf %b at_max %b expected FF %b 1",
                 i, count[7:0], ovf_pulse[0], at_max[0], (i > 0));
      end
    end
    vectors++;
    if (ovf_sticky[0] !== STICKY) begin
      miscompares++;
      $display("[TB] FAIL sat_up_sticky: got %b expected %b", ovf_sticky[0], STICKY);
    end
  endtask

  task automatic test_wrap_down();
    do_reset();
    mode = 4'b0001; load = 2'b01; load_value = 16'h0002;
    tick();
    load = 2'b00; step = 4'd3; down = 2'b01;
    tick();
    vectors++;
    if (count[7:0] !== 8'hFF || udf_pulse[0] !== 1'b1 || udf_sticky[0] !== STICKY) begin
      miscompares++;
      $display("[TB] FAIL wrap_down: count %h udf %b sticky %b expected FF 1 %b",
               count[7:0], udf_pulse[0], udf_sticky[0], STICKY);
    end
    down = 2'b00;
    tick();
    vectors++;
    if (count[7:0] !== 8'hFF || udf_pulse[0] !== 1'b0 || udf_sticky[0] !== STICKY) begin
      miscompares++;
      $display("[TB] FAIL wrap_down_after: count %h udf %b sticky %b expected FF 0 %b",
               count[7:0], udf_pulse[0], udf_sticky[0], STICKY);
    end
  endtask

  task automatic test_reload_up();
    logic [7:0] exp_c[3];
    logic       exp_o[3];
    exp_c[0] = 8'hF8; exp_c[1] = 8'hF0; exp_c[2] = 8'hF8;
    exp_o[0] = 1'b0;  exp_o[1] = 1'b1;  exp_o[2] = 1'b0;
    do_reset();
    mode = 4'b0010; load = 2'b01; load_value = 16'h00F0;
    tick();
    load = 2'b00; step = 4'd8; up = 2'b01;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (count[7:0] !== exp_c[i] || ovf_pulse[0] !== exp_o[i]) begin
        miscompares++;
        $display("[TB] FAIL reload_up[%0d]: count %h ovf %b expected %h %b",
                 i, count[7:0], ovf_pulse[0], exp_c[i], exp_o[i]);
      end
    end
  endtask

  task automatic test_priority();
    do_reset();
    mode = 4'b0000; load = 2'b11; load_value = 16'h1020;
    tick();
    load = 2'b00; step = 4'd1; up = 2'b01; down = 2'b01;
    tick();
    vectors++;
    if (count !== 16'h1020) begin
      miscompares++;
      $display("[TB] FAIL prio_hold: got %h expected 1020", count);
    end
    load = 2'b01; load_value = 16'h0033; down = 2'b00; up = 2'b01;
    tick();
    vectors++;
    if (count !== 16'h1033 || ovf_pulse !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL prio_load: got %h ovf %b expected 1033 00", count, ovf_pulse);
    end
    load = 2'b00; up = 2'b10; step = 4'd2;
    tick();
    vectors++;
    if (count !== 16'h1233) begin
      miscompares++;
      $display("[TB] FAIL independence: got %h expected 1233", count);
    end
  endtask

  task automatic test_sticky();
    do_reset();
    mode = 4'b0000; load = 2'b01; load_value = 16'h00FF;
    tick();
    load = 2'b00; step = 4'd1; up = 2'b01;
    tick();
    vectors++;
    if (ovf_pulse[0] !== 1'b1 || ovf_sticky[0] !== STICKY) begin
      miscompares++;
      $display("[TB] FAIL sticky_set: ovf %b sticky %b expected 1 %b",
               ovf_pulse[0], ovf_sticky[0], STICKY);
    end
    up = 2'b00; flag_clr = 2'b01;
    tick();
    vectors++;
    if (ovf_sticky[0] !== 1'b0 || ovf_pulse[0] !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL sticky_clear: sticky %b ovf %b expected 0 0",
               ovf_sticky[0], ovf_pulse[0]);
    end
    up = 2'b01;
    tick();
    vectors++;
    if (ovf_sticky[0] !== STICKY || ovf_pulse[0] !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL sticky_set_wins: sticky %b ovf %b expected %b 1",
               ovf_sticky[0], ovf_pulse[0], STICKY);
    end
    clear_inputs();
  endtask

  task automatic test_random();
    do_reset();
    for (int it = 0; it < 300; it++) begin
      for (int ch = 0; ch < 2; ch++) begin
        load[ch]     = ($urandom_range(0, 9) == 0);
        up[ch]       = $urandom_range(0, 1);
        down[ch]     = $urandom_range(0, 1);
        flag_clr[ch] = ($urandom_range(0, 7) == 0);
      end
      load_value = 16'($urandom);
      step       = 4'($urandom);
      mode       = 4'($urandom);
      tick();
      for (int ch = 0; ch < 2; ch++) begin
        logic [7:0] exp_c;
        logic [5:0] exp_f;
        logic [5:0] got_f;
        exp_c = 8'(m_cnt[ch]);
        exp_f = {(m_cnt[ch] == 255), (m_cnt[ch] == 0), m_ovf[ch], m_udf[ch], m_os[ch], m_us[ch]};
        got_f = {at_max[ch], at_min[ch], ovf_pulse[ch], udf_pulse[ch], ovf_sticky[ch], udf_sticky[ch]};
        vectors++;
        if (count[ch*8 +: 8] !== exp_c) begin
          miscompares++;
          $display("[TB] FAIL rand_count it%0d ch%0d: got %h expected %h",
                   it, ch, count[ch*8 +: 8], exp_c);
        end
        vectors++;
        if (got_f !== exp_f) begin
          miscompares++;
          $display("[TB] FAIL rand_flags it%0d ch%0d: got %b expected %b", it, ch, got_f, exp_f);
        end
      end
    end
    clear_inputs();
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b0;
    clear_inputs();
    model_reset();
    test_reset();
    test_sat_up();
    test_wrap_down();
    test_reload_up();
    test_priority();
    test_sticky();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/multi_channel_counter.md
# multi_channel_counter

N-channel parametrised up/down counter that generalises the single-channel counter: per-channel load, programmable step size, and a per-channel overflow mode (saturate, wrap, or reload). Each channel also has terminal-count decode and overflow/underflow event outputs. It sits in the timer/event-counting fabric, with one instance serving several independent counting streams on a shared clock.

## Interface
- WIDTH, 8, counter width in bits per channel (≥2)
- N_CH, 2, number of independent channels (≥1)
- STEP_W, 4, width of the shared step input (1 ≤ STEP_W ≤ WIDTH)
- clk  input  1  rising-edge clock for all state
- rst  input  1  asynchronous, active-high reset
- load  input  N_CH  per-channel synchronous load strobe
- load_value  input  N_CH*WIDTH  per-channel load value; channel i occupies bits [i*WIDTH +: WIDTH]
- up  input  N_CH  per-channel count-up request
- down  input  N_CH  per-channel count-down request
- step  input  STEP_W  increment/decrement amount, shared by all channels, zero-extended to WIDTH
- mode  input  N_CH*2  per-channel mode: 00 SAT, 01 WRAP, 10 RELOAD, 11 treated as SAT
- count  output  N_CH*WIDTH  registered count per channel
- at_max  output  N_CH  count equals 2^WIDTH-1
- at_min  output  N_CH  count equals 0
- ovf_pulse  output  N_CH  registered one-cycle overflow event
- udf_pulse  output  N_CH  registered one-cycle underflow event
- flag_clr  input  N_CH  clears the sticky flags (see Configuration)
- ovf_sticky  output  N_CH  sticky overflow flag
- udf_sticky  output  N_CH  sticky underflow flag

## Operation
- Reset (async, immediate) clears all of the following to 0: count, the per-channel reload register, ovf_pulse, udf_pulse, and both sticky flags. As a result, at_min=1 and at_max=0.
- Per-channel priority at each edge: load > (up XOR down) > hold.
- load: count ← load_value, and the reload register ← load_value. Loading raises no event.
- up&down both high, or neither high: hold. step=0 with up or down: hold, no event.
- Up arithmetic is done in WIDTH+1 bits: sum = count + step.
  - Overflow means sum > 2^WIDTH-1.
  - SAT: count ← all-ones.
  - WRAP: count ← sum[WIDTH-1:0].
  - RELOAD: count ← reload register.
- Down arithmetic: underflow means step > count.
  - SAT: count ← 0.
  - WRAP: count ← (count − step) mod 2^WIDTH.
  - RELOAD: count ← reload register.
- An overflow or underflow event asserts ovf_pulse or udf_pulse for exactly the cycle following the edge that applied it. This applies in every mode, including repeated saturating attempts at a boundary.
- mode is sampled every cycle and can change at any time; it takes effect on the next edge.
- Channels are fully independent; no cross-channel interaction exists.

## Timing
- Input-to-count latency is one clock: inputs are sampled at edge k and count is valid after edge k.
- ovf_pulse and udf_pulse are registered and coincide with the updated count.
- at_max and at_min are combinational decodes of the count register only (no input paths).
- Sticky flags update on the same edge as the pulses.
- Asserting rst mid-count forces all outputs to their reset values without waiting for a clock edge. The first count operation takes effect on the first edge after rst deasserts.

## Configuration
- COUNTER_STICKY_FLAGS_EN defined:
  - ovf_sticky and udf_sticky set on any event and hold until flag_clr.
  - flag_clr clears the flag on the next edge.
  - If an event and flag_clr occur in the same cycle, set wins (the flag stays 1).
- Macro undefined:
  - No sticky registers are built.
  - ovf_sticky and udf_sticky are tied to 0, and flag_clr is ignored.
  - The port list is identical in both builds.

## Structure
- Package counter_pkg holds:
  - typedef enum logic [1:0] cnt_mode_t {MODE_SAT, MODE_WRAP, MODE_RELOAD, MODE_RSVD}
  - localparams for the mode encodings
- Sub-module counter_channel implements one channel: count register, reload register, event logic, and sticky flags.
- multi_channel_counter is a generate loop of N_CH counter_channel instances plus the bus slicing.

## Test plan
All scenarios use WIDTH=8, N_CH=2, STEP_W=4, macro defined.
- Reset: count ch0 up to 0x05, assert rst between edges → count=0x00 immediately with no clock edge; at_min=1; all flags 0.
- SAT up: load 0xFE, step=1, up for 3 cycles → count FF, FF, FF; ovf_pulse 0, 1, 1; at_max=1; ovf_sticky=1.
- WRAP down: load 0x02, step=3, down 1 cycle → count=0xFF, udf_pulse=1 for one cycle, udf_sticky=1.
- RELOAD up: load 0xF0, step=8, up for 3 cycles → count F8, F0, F8; ovf_pulse 0, 1, 0.
- Priority and independence:
  - ch0 up=down=1 → hold.
  - ch0 load=1, load_value=0x33, up=1 → count=0x33.
  - Meanwhile ch1 up with step=2 from 0x10 → 0x12 with ch0 unaffected.
- Sticky: flag_clr alone clears ovf_sticky next edge. flag_clr in the same cycle as a new overflow → ovf_sticky remains 1.
